// File: rtl/bot_velocity_write_scheduler_if.sv
// rtl/bot_velocity_write_scheduler_if.sv - shared velocity-write port between scheduler and bot-link writer
interface bot_velocity_write_scheduler_if #(
  parameter int VW = 16
);
  logic          wr_valid;
  logic [1:0]    wr_bot_id;
  logic [VW-1:0] wr_vx;
  logic [VW-1:0] wr_vy;
  logic          wr_ack;

  modport master (
    output wr_valid,
    output wr_bot_id,
    output wr_vx,
    output wr_vy,
    input  wr_ack
  );

  modport slave (
    input  wr_valid,
    input  wr_bot_id,
    input  wr_vx,
    input  wr_vy,
    output wr_ack
  );
endinterface

// File: rtl/bot_velocity_write_scheduler.sv
// rtl/bot_velocity_write_scheduler.sv - batches six bot velocities and writes them round-robin to one port
// A write_check edge snapshots a batch; one further batch may be queued while busy.
module bot_velocity_write_scheduler #(
  parameter int SETTLE_CYC  = 300,
  parameter int TIMEOUT_CYC = 4096,
  parameter int VW          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VW-1:0]                  vx1_bin,
  input  logic [VW-1:0]                  vy1_bin,
  input  logic [VW-1:0]                  vx2_bin,
  input  logic [VW-1:0]                  vy2_bin,
  input  logic [VW-1:0]                  vx3_bin,
  input  logic [VW-1:0]                  vy3_bin,
  input  logic                           write_check,
  input  logic [2:0]                     bot_rdy,
  bot_velocity_write_scheduler_if.master wr,
  output logic                           en,
  output logic                           busy,
  output logic [2:0]                     dropped
);
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ARB, S_WRITE, S_DONE} state_t;
  typedef logic [2:0][VW-1:0] vel_set_t;

  state_t        state_q, state_d;
  logic          wc_q, wc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    dropped_q, dropped_d;
  logic          queued_q, queued_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    gnt_q, gnt_d;
  vel_set_t      bvx_q, bvx_d, bvy_q, bvy_d;
  vel_set_t      nvx_q, nvx_d, nvy_q, nvy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [1:0]    wr_id_q, wr_id_d;
  logic [VW-1:0] wr_vx_q, wr_vx_d, wr_vy_q, wr_vy_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;

  logic          req;
  logic          start;
  logic [2:0]    elig;
  logic [1:0]    pick;
  vel_set_t      live_vx, live_vy, start_vx, start_vy;

  // Bot indices are 0..2 internally; the first eligible bot at or after p wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] e, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 2; i >= 0; i--) begin
      idx = (int'(p) + i >= 3) ? 2'(int'(p) + i - 3) : 2'(int'(p) + i);
      if (e[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    live_vx = {vx3_bin, vx2_bin, vx1_bin};
    live_vy = {vy3_bin, vy2_bin, vy1_bin};
    req     = write_check & ~wc_q;
    elig    = pending_q & bot_rdy;
    pick    = rr_pick(elig, rr_q);

    state_d    = state_q;
    wc_d       = write_check;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    dropped_d  = dropped_q;
    queued_d   = queued_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    bvx_d      = bvx_q;
    bvy_d      = bvy_q;
    nvx_d      = nvx_q;
    nvy_d      = nvy_q;
    wr_valid_d = wr_valid_q;
    wr_id_d    = wr_id_q;
    wr_vx_d    = wr_vx_q;
    wr_vy_d    = wr_vy_q;
    en_d       = 1'b0;
    busy_d     = busy_q;
    start      = 1'b0;
    start_vx   = live_vx;
    start_vy   = live_vy;

    // One-deep look-ahead: the latest request during a batch replaces any earlier one.
    if (req && (state_q inside {S_SETTLE, S_ARB, S_WRITE})) begin
      nvx_d    = live_vx;
      nvy_d    = live_vy;
      queued_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: start = req;
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ARB: begin
        if (elig != 3'b000) begin
          gnt_d      = pick;
          wr_valid_d = 1'b1;
          wr_id_d    = pick + 2'd1;
          wr_vx_d    = bvx_q[pick];
          wr_vy_d    = bvy_q[pick];
          state_d    = S_WRITE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          dropped_d = dropped_q | pending_q;
          pending_d = 3'b000;
          en_d      = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        // Timeout count is frozen here; only wr_ack ends the handshake.
        if (wr.wr_ack) begin
          wr_valid_d = 1'b0;
          wr_id_d    = 2'd0;
          pending_d  = pending_q & ~(3'b001 << gnt_q);
          rr_d       = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
          if (pending_d == 3'b000) begin
            en_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_ARB;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (req) begin
          start = 1'b1;
        end else if (queued_q) begin
          start    = 1'b1;
          start_vx = nvx_q;
          start_vy = nvy_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      bvx_d     = start_vx;
      bvy_d     = start_vy;
      pending_d = 3'b111;
      dropped_d = 3'b000;
      busy_d    = 1'b1;
      cnt_d     = '0;
      queued_d  = 1'b0;
      state_d   = S_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wc_q       <= 1'b0;
      cnt_q      <= '0;
      pending_q  <= 3'b000;
      dropped_q  <= 3'b000;
      queued_q   <= 1'b0;
      rr_q       <= 2'd0;
      gnt_q      <= 2'd0;
      bvx_q      <= '0;
      bvy_q      <= '0;
      nvx_q      <= '0;
      nvy_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_id_q    <= 2'd0;
      wr_vx_q    <= '0;
      wr_vy_q    <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
      queued_q   <= queued_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      bvx_q      <= bvx_d;
      bvy_q      <= bvy_d;
      nvx_q      <= nvx_d;
      nvy_q      <= nvy_d;
      wr_valid_q <= wr_valid_d;
      wr_id_q    <= wr_id_d;
      wr_vx_q    <= wr_vx_d;
      wr_vy_q    <= wr_vy_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
    end
  end

  assign wr.wr_valid  = wr_valid_q;
  assign wr.wr_bot_id = wr_id_q;
  assign wr.wr_vx     = wr_vx_q;
  assign wr.wr_vy     = wr_vy_q;
  assign en           = en_q;
  assign busy         = busy_q;
  assign dropped      = dropped_q;
endmodule

// File: tb/tb_bot_velocity_write_scheduler.sv
// tb/tb_bot_velocity_write_scheduler.sv - table-driven bench for bot_velocity_write_scheduler
module tb_bot_velocity_write_scheduler;
  localparam int SETTLE = 4;
  localparam int TMO    = 16;
  localparam int VW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] vx_in [3];
  logic [VW-1:0] vy_in [3];
  logic          write_check = 1'b0;
  logic [2:0]    bot_rdy = 3'b000;
  logic          en, busy;
  logic [2:0]    dropped;

  int checks = 0;
  int errors = 0;

  int          n_log;
  logic [1:0]  log_id [16];
  logic [15:0] log_vx [16];

  bot_velocity_write_scheduler_if #(.VW(VW)) wif ();

  bot_velocity_write_scheduler #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO),
    .VW         (VW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vx1_bin    (vx_in[0]),
    .vy1_bin    (vy_in[0]),
    .vx2_bin    (vx_in[1]),
    .vy2_bin    (vy_in[1]),
    .vx3_bin    (vx_in[2]),
    .vy3_bin    (vy_in[2]),
    .write_check(write_check),
    .bot_rdy    (bot_rdy),
    .wr         (wif.master),
    .en         (en),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      rdy0;
    logic [2:0]      rdy1;
    logic [7:0]      ack_dly;
    logic [2:0][1:0] ord;
    logic [1:0]      n;
    logic [2:0]      drop;
    logic [7:0]      lat;
    logic [15:0]     vx1;
    logic [15:0]     vy1;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [2:0] r0, input logic [2:0] r1, input int ad,
                              input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                              input int n, input logic [2:0] dr, input int lat,
                              input logic [15:0] vx, input logic [15:0] vy);
    mk.rdy0    = r0;
    mk.rdy1    = r1;
    mk.ack_dly = 8'(ad);
    mk.ord     = {c, b, a};
    mk.n       = 2'(n);
    mk.drop    = dr;
    mk.lat     = 8'(lat);
    mk.vx1     = vx;
    mk.vy1     = vy;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_vx(input logic [15:0] base, input int k);
    return base + 16'(k * 256);
  endfunction

  function automatic logic [15:0] exp_vy(input logic [15:0] base, input int k);
    return base - 16'(k * 16);
  endfunction

  task automatic set_vel(input logic [15:0] vx1, input logic [15:0] vy1);
    for (int k = 0; k < 3; k++) begin
      vx_in[k] = exp_vx(vx1, k);
      vy_in[k] = exp_vy(vy1, k);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    wif.wr_ack  = 1'b0;
    write_check = 1'b0;
    bot_rdy     = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic auto_run(input int max_en, input int budget, output int n_en);
    n_en = 0;
    for (int c = 0; c < budget && n_en < max_en; c++) begin
      @(posedge clk);
      #1;
      if (wif.wr_ack) begin
        wif.wr_ack = 1'b0;
      end else if (wif.wr_valid) begin
        if (n_log < 16) begin
          log_id[n_log] = wif.wr_bot_id;
          log_vx[n_log] = wif.wr_vx;
        end
        n_log++;
        wif.wr_ack = 1'b1;
      end
      if (en) n_en++;
    end
    wif.wr_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc, nw, held, k;
    logic       in_req, stable, done;
    logic [1:0] id0, eid;
    logic [15:0] vx0, vy0;
    do_reset();
    set_vel(v.vx1, v.vy1);
    bot_rdy     = v.rdy0;
    write_check = 1'b1;
    cyc = 0; nw = 0; held = 0;
    in_req = 1'b0; stable = 1'b1; done = 1'b0;
    id0 = 2'd0; vx0 = 16'd0; vy0 = 16'd0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        write_check = 1'b0;
        for (int j = 0; j < 3; j++) begin
          vx_in[j] = 16'hDEAD;
          vy_in[j] = 16'hBEEF;
        end
      end
      if (wif.wr_ack) begin
        wif.wr_ack = 1'b0;
        chk("ack_release_valid", wif.wr_valid, 0);
      end else if (in_req) begin
        held++;
        if (!wif.wr_valid || wif.wr_bot_id !== id0 || wif.wr_vx !== vx0 || wif.wr_vy !== vy0)
          stable = 1'b0;
      end else if (wif.wr_valid) begin
        nw++;
        in_req = 1'b1;
        held   = 0;
        id0    = wif.wr_bot_id;
        vx0    = wif.wr_vx;
        vy0    = wif.wr_vy;
        if (nw <= 3) begin
          eid = v.ord[nw-1];
          k   = int'(eid) - 1;
          chk("grant_id", id0, eid);
          chk("wr_vx", vx0, exp_vx(v.vx1, k));
          chk("wr_vy", vy0, exp_vy(v.vy1, k));
        end
        if (nw == 1 && v.lat != 8'd0) chk("first_latency", cyc, v.lat);
      end
      if (in_req && held >= int'(v.ack_dly)) begin
        wif.wr_ack = 1'b1;
        in_req     = 1'b0;
        if (nw == 1) bot_rdy = v.rdy1;
      end
      if (en) begin
        chk("busy_at_en", busy, 0);
        done = 1'b1;
      end
    end
    chk("en_seen", done, 1);
    wif.wr_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("en_one_cycle", en, 0);
    chk("write_count", nw, v.n);
    chk("dropped", dropped, v.drop);
    chk("hold_stable", stable, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int ne, w;
    vecs[0] = mk(3'b111, 3'b111, 0,  2'd1, 2'd2, 2'd3, 3, 3'b000, SETTLE + 2, 16'h0800, 16'h0400);
    vecs[1] = mk(3'b100, 3'b111, 0,  2'd3, 2'd1, 2'd2, 3, 3'b000, SETTLE + 2, 16'h1234, 16'hF800);
    vecs[2] = mk(3'b111, 3'b111, 10, 2'd1, 2'd2, 2'd3, 3, 3'b000, SETTLE + 2, 16'h0A00, 16'h0050);
    vecs[3] = mk(3'b101, 3'b101, 0,  2'd1, 2'd3, 2'd0, 2, 3'b010, SETTLE + 2, 16'h7FFF, 16'h8000);
    vecs[4] = mk(3'b000, 3'b000, 0,  2'd0, 2'd0, 2'd0, 0, 3'b111, 0,          16'h0001, 16'hFFFF);
    vecs[5] = mk(3'b010, 3'b111, 3,  2'd2, 2'd3, 2'd1, 3, 3'b000, SETTLE + 2, 16'h3C00, 16'hC400);

    set_vel(16'h0000, 16'h0000);
    wif.wr_ack = 1'b0;
    do_reset();
    chk("rst_wr_valid", wif.wr_valid, 0);
    chk("rst_wr_bot_id", wif.wr_bot_id, 0);
    chk("rst_wr_vx", wif.wr_vx, 0);
    chk("rst_wr_vy", wif.wr_vy, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Two requests while busy: only the latest is queued.
    do_reset();
    bot_rdy = 3'b111;
    n_log   = 0;
    set_vel(16'h0AAA, 16'h0123);
    write_check = 1'b1;
    @(posedge clk); #1; write_check = 1'b0; set_vel(16'h0100, 16'h0222);
    @(posedge clk); #1; write_check = 1'b1;
    @(posedge clk); #1; write_check = 1'b0; set_vel(16'h0200, 16'h0456);
    @(posedge clk); #1; write_check = 1'b1;
    @(posedge clk); #1; write_check = 1'b0; set_vel(16'hDEAD, 16'hBEEF);
    chk("queue_busy", busy, 1);
    auto_run(2, 200, ne);
    chk("queue_en_count", ne, 2);
    chk("queue_writes", n_log, 6);
    chk("q1_bot1_vx", log_vx[0], 16'h0AAA);
    chk("q2_first_id", log_id[3], 1);
    chk("q2_bot1_vx", log_vx[3], 16'h0200);
    chk("q2_bot3_vx", log_vx[5], 16'h0400);

    // Reset in the middle of a write, then a clean batch.
    do_reset();
    bot_rdy = 3'b111;
    set_vel(16'h0333, 16'h0044);
    write_check = 1'b1;
    @(posedge clk); #1; write_check = 1'b0;
    w = 0;
    while (!wif.wr_valid && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("pre_rst_valid", wif.wr_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_valid", wif.wr_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_bot_id", wif.wr_bot_id, 0);
    rst = 1'b0;
    wif.wr_ack = 1'b1;
    @(posedge clk); #1;
    wif.wr_ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_valid", wif.wr_valid, 0);
    n_log = 0;
    set_vel(16'h0777, 16'h0011);
    write_check = 1'b1;
    auto_run(2, 60, ne);
    write_check = 1'b0;
    chk("rec_en_count", ne, 1);
    chk("rec_writes", n_log, 3);
    chk("rec_first_id", log_id[0], 1);
    chk("rec_bot3_vx", log_vx[2], 16'h0977);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
